// File: rtl/im_loader.sv
// im_loader: boot-time byte-stream to instruction-memory word writer
module im_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_hold_o
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [16:0] DEPTH = 17'(DEPTH_WORDS);
  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [12:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d, addr_q, addr_d, wdata_q, wdata_d;
  logic        acc;
  logic [15:0] n_new;
  assign rx_ready_o = state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA;
  assign im_we_o    = state_q == S_WRITE;
  assign busy_o     = rx_ready_o || im_we_o;
  assign done_o     = state_q == S_DONE;
  assign err_o      = state_q == S_ERR;
  assign cpu_hold_o = !done_o;
  assign im_addr_o  = addr_q;
  assign im_wdata_o = wdata_q;
  assign acc        = rx_valid_i && rx_ready_o;
  assign n_new      = {len_q[15:8], rx_data_i};
  // next-state: length header, byte packing, and the single-cycle write slot
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_i) begin
        state_d = S_LEN_HI;
        idx_d   = '0;
        cnt_d   = '0;
      end
      S_LEN_HI: if (acc) begin
        len_d[15:8] = rx_data_i;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (acc) begin
        len_d[7:0] = rx_data_i;
        state_d    = n_new == 16'd0 ? S_DONE : {1'b0, n_new} > DEPTH ? S_ERR : S_DATA;
      end
      S_DATA: if (acc) begin
        word_d = {word_q[23:0], rx_data_i};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_WRITE;
          addr_d  = BASE_ADDR + {17'd0, idx_q, 2'b00};
          wdata_d = {word_q[23:0], rx_data_i};
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 13'd1;
        cnt_d   = '0;
        state_d = {3'd0, idx_q} + 16'd1 == len_q ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; a reset drops any partially assembled word
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized directed bench for im_loader against an image model
module tb_im_loader;
  logic        clk, reset, start, rx_valid, rx_ready, im_we, busy, done, err, cpu_hold;
  logic [7:0]  rx_data;
  logic [31:0] im_addr, im_wdata;
  int          errors = 0, checks = 0, nwr = 0;
  logic [31:0] img[$];
  im_loader dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .rx_ready_o(rx_ready), .im_we_o(im_we),
    .im_addr_o(im_addr), .im_wdata_o(im_wdata), .busy_o(busy), .done_o(done),
    .err_o(err), .cpu_hold_o(cpu_hold)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask
  // count writes and make sure no byte can be taken during a write cycle
  always @(negedge clk) if (im_we) begin
    nwr++;
    checks++;
    assert (rx_ready === 1'b0) else begin
      errors++;
      $error("FAIL ready_in_write: observed=%0b expected=0", rx_ready);
    end
  end
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input logic [7:0] b, input int maxgap);
    int t = 0;
    rx_valid = 0;
    repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    rx_valid = 1;
    rx_data  = b;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=ready_low expected=ready_high");
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic run_load(input int n, input int maxgap, input bit midstart);
    int w0;
    logic [31:0] w;
    pulse_start();
    chk("done_clr", done, 0);
    chk("busy_load", busy, 1);
    w0 = nwr;
    send(8'(n >> 8), maxgap);
    send(8'(n), maxgap);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        send(w[31 - 8 * k -: 8], maxgap);
        if (midstart && i == 0 && k == 1) pulse_start();
      end
      chk("we", im_we, 1);
      chk("addr", im_addr, 32'h3000 + 32'(4 * i));
      chk("wdata", im_wdata, w);
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("cpu_hold_rel", cpu_hold, 0);
    chk("busy_end", busy, 0);
    chk("nwrites", nwr - w0, n);
  endtask
  initial begin
    int w0;
    reset = 0; start = 0; rx_valid = 0; rx_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 32'h3000);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hold", cpu_hold, 1);
    reset = 1;
    @(negedge clk);
    img = '{32'h3C010000, 32'h34210001};
    run_load(2, 0, 0);
    w0 = nwr;
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_nwr", nwr - w0, 0);
    pulse_start();
    send(8'h10, 0);
    send(8'h01, 0);
    chk("big_err", err, 1);
    chk("big_hold", cpu_hold, 1);
    chk("big_done", done, 0);
    chk("big_nwr", nwr - w0, 0);
    img = {};
    repeat (3) img.push_back($urandom);
    run_load(3, 0, 0);
    chk("err_clr", err, 0);
    img = '{32'h3C010000, 32'h34210001};
    run_load(2, 5, 0);
    pulse_start();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    w0 = nwr;
    reset = 0;
    @(negedge clk);
    chk("mid_ready", rx_ready, 0);
    chk("mid_we", im_we, 0);
    chk("mid_addr", im_addr, 32'h3000);
    chk("mid_wdata", im_wdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_hold", cpu_hold, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_nwr", nwr - w0, 0);
    img = {};
    repeat (2) img.push_back($urandom);
    run_load(2, 2, 0);
    img = {};
    repeat (4095) img.push_back($urandom);
    img.push_back(32'hFFFFFFFF);
    run_load(4096, 1, 1);
    chk("last_addr", im_addr, 32'h6FFC);
    chk("last_data", im_wdata, 32'hFFFFFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
